// File: rtl/accel_mem_bridge_mp.sv
// Round-robin bridge from NUM_PORTS packed-command accelerator ports to one pipelined
// Avalon-MM memory master; reads return in order to their originating port.
module accel_mem_bridge_mp #(
    parameter int NUM_PORTS   = 2,
    parameter int DATA_W      = 64,
    parameter int MAX_PENDING = 8
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [NUM_PORTS*(DATA_W+34)-1:0]  avs_accel_writedata,
    input  logic [NUM_PORTS-1:0]              avs_accel_read,
    input  logic [NUM_PORTS-1:0]              avs_accel_write,
    output logic [NUM_PORTS-1:0]              avs_accel_waitrequest,
    output logic [NUM_PORTS*DATA_W-1:0]       avs_accel_readdata,
    output logic [NUM_PORTS-1:0]              avs_accel_readdatavalid,
    output logic [31:0]                       avm_mem_address,
    output logic                              avm_mem_read,
    output logic                              avm_mem_write,
    output logic [DATA_W-1:0]                 avm_mem_writedata,
    output logic [DATA_W/8-1:0]               avm_mem_byteenable,
    input  logic                              avm_mem_waitrequest,
    input  logic [DATA_W-1:0]                 avm_mem_readdata,
    input  logic                              avm_mem_readdatavalid
);
    localparam int ACC_W = DATA_W + 34;
    localparam int BE_W  = DATA_W / 8;
    localparam int OFF_W = $clog2(BE_W);
    localparam int PW    = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int QW    = (MAX_PENDING > 1) ? $clog2(MAX_PENDING) : 1;
    localparam int CW    = $clog2(MAX_PENDING + 1);

    function automatic logic [BE_W-1:0] lane_mask(input logic [1:0] size, input logic [OFF_W-1:0] off);
        logic [7:0]      base;
        logic [BE_W+7:0] shifted;
        case (size)
            2'd0:    base = 8'h01;
            2'd1:    base = 8'h03;
            2'd2:    base = 8'h0F;
            default: base = 8'hFF;
        endcase
        shifted   = {{BE_W{1'b0}}, base} << off;
        lane_mask = shifted[BE_W-1:0];
    endfunction

    function automatic logic [DATA_W-1:0] data_mask(input logic [1:0] size);
        logic [6:0] nbits;
        nbits     = 7'd8 << size;
        data_mask = ~({DATA_W{1'b1}} << nbits);
    endfunction

    function automatic logic [PW-1:0] rr_idx(input logic [PW-1:0] last, input int k);
        rr_idx = PW'((int'(last) + k) % NUM_PORTS);
    endfunction

    logic [ACC_W-1:0]  cmd_s [NUM_PORTS];
    logic [NUM_PORTS-1:0] req_s, eligible_s, grant_s;
    logic [PW-1:0]     grant_idx_s, last_grant_r;
    logic              grant_any_s, cr_load_s, cr_valid_s, sel_wr_s, push_s, pop_s;
    logic [ACC_W-1:0]  sel_cmd_s;
    logic [31:0]       sel_addr_s;
    logic [OFF_W-1:0]  sel_off_s;
    logic              cr_rd_r, cr_wr_r;
    logic [31:0]       cr_addr_r;
    logic [DATA_W-1:0] cr_wdata_r;
    logic [BE_W-1:0]   cr_be_r;
    logic [PW-1:0]     fifo_port_r [MAX_PENDING];
    logic [OFF_W-1:0]  fifo_off_r  [MAX_PENDING];
    logic [1:0]        fifo_size_r [MAX_PENDING];
    logic [QW-1:0]     wr_ptr_r, rd_ptr_r;
    logic [CW-1:0]     pend_cnt_r;
    logic [NUM_PORTS-1:0]        rsp_valid_r;
    logic [NUM_PORTS*DATA_W-1:0] rsp_data_r;

    // Split the packed command bus and decide which ports may compete this cycle
    always_comb begin
        for (int i = 0; i < NUM_PORTS; i++) begin
            cmd_s[i] = avs_accel_writedata[i*ACC_W +: ACC_W];
        end
        req_s      = avs_accel_read | avs_accel_write;
        eligible_s = avs_accel_write | (avs_accel_read & {NUM_PORTS{pend_cnt_r < CW'(MAX_PENDING)}});
    end

    assign cr_valid_s = cr_rd_r | cr_wr_r;
    assign cr_load_s  = ~cr_valid_s | ~avm_mem_waitrequest;

    // Round-robin search starting one past the previous winner
    always_comb begin
        logic hit_v;
        grant_any_s = 1'b0;
        grant_idx_s = last_grant_r;
        grant_s     = '0;
        for (int k = 1; k <= NUM_PORTS; k++) begin
            hit_v       = ~grant_any_s & eligible_s[rr_idx(last_grant_r, k)] & cr_load_s & ~reset;
            grant_idx_s = hit_v ? rr_idx(last_grant_r, k) : grant_idx_s;
            grant_any_s = grant_any_s | hit_v;
        end
        if (grant_any_s) begin
            grant_s[grant_idx_s] = 1'b1;
        end else begin
            grant_s = '0;
        end
    end

    assign sel_cmd_s  = cmd_s[grant_idx_s];
    assign sel_addr_s = sel_cmd_s[31:0];
    assign sel_off_s  = sel_addr_s[OFF_W-1:0];
    assign sel_wr_s   = avs_accel_write[grant_idx_s];
    assign push_s     = grant_any_s & ~sel_wr_s;
    assign pop_s      = avm_mem_readdatavalid & (pend_cnt_r != '0);

    // Command register: lane-encode the granted request, hold it while memory stalls
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cr_rd_r      <= 1'b0;
            cr_wr_r      <= 1'b0;
            cr_addr_r    <= 32'h0;
            cr_wdata_r   <= '0;
            cr_be_r      <= '0;
            last_grant_r <= PW'(NUM_PORTS - 1);
        end else if (cr_load_s) begin
            cr_rd_r <= grant_any_s & ~sel_wr_s;
            cr_wr_r <= grant_any_s & sel_wr_s;
            if (grant_any_s) begin
                cr_addr_r    <= {sel_addr_s[31:OFF_W], {OFF_W{1'b0}}};
                cr_wdata_r   <= sel_cmd_s[DATA_W+31:32] << {sel_off_s, 3'b000};
                cr_be_r      <= lane_mask(sel_cmd_s[DATA_W+33:DATA_W+32], sel_off_s);
                last_grant_r <= grant_idx_s;
            end
        end
    end

    // Outstanding-read bookkeeping (pointers and occupancy)
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_r   <= '0;
            rd_ptr_r   <= '0;
            pend_cnt_r <= '0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= (wr_ptr_r == QW'(MAX_PENDING - 1)) ? '0 : wr_ptr_r + QW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= (rd_ptr_r == QW'(MAX_PENDING - 1)) ? '0 : rd_ptr_r + QW'(1);
            end
            case ({push_s, pop_s})
                2'b10:   pend_cnt_r <= pend_cnt_r + CW'(1);
                2'b01:   pend_cnt_r <= pend_cnt_r - CW'(1);
                default: pend_cnt_r <= pend_cnt_r;
            endcase
        end
    end

    // Outstanding-read storage; contents are meaningless outside the pointer window
    always_ff @(posedge clk) begin
        if (push_s) begin
            fifo_port_r[wr_ptr_r] <= grant_idx_s;
            fifo_off_r[wr_ptr_r]  <= sel_off_s;
            fifo_size_r[wr_ptr_r] <= sel_cmd_s[DATA_W+33:DATA_W+32];
        end
    end

    // Response stage: align and mask the returning word, strobe only the owning port
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rsp_valid_r <= '0;
            rsp_data_r  <= '0;
        end else begin
            rsp_valid_r <= '0;
            if (pop_s) begin
                rsp_valid_r[fifo_port_r[rd_ptr_r]] <= 1'b1;
                rsp_data_r[int'(fifo_port_r[rd_ptr_r])*DATA_W +: DATA_W] <=
                    (avm_mem_readdata >> {fifo_off_r[rd_ptr_r], 3'b000}) & data_mask(fifo_size_r[rd_ptr_r]);
            end
        end
    end

    assign avs_accel_waitrequest   = req_s & ~grant_s;
    assign avs_accel_readdata      = rsp_data_r;
    assign avs_accel_readdatavalid = rsp_valid_r;
    assign avm_mem_address         = cr_addr_r;
    assign avm_mem_read            = cr_rd_r;
    assign avm_mem_write           = cr_wr_r;
    assign avm_mem_writedata       = cr_wdata_r;
    assign avm_mem_byteenable      = cr_be_r;
endmodule

// File: tb/tb_accel_mem_bridge_mp.sv
// Directed bench for accel_mem_bridge_mp (2 ports, 64-bit, 8 pending): a vector table
// for single-cycle issue behaviour plus hand sequences for the multi-cycle cases.
module tb_accel_mem_bridge_mp;
    localparam int NP = 2;
    localparam int DW = 64;
    localparam int AW = DW + 34;
    localparam logic [63:0] MEMD = 64'h1122334455667788;

    logic clk = 1'b0;
    logic reset;
    logic [NP*AW-1:0] wdata;
    logic [NP-1:0]    rd, wr, waitreq, rvalid;
    logic [NP*DW-1:0] rdata;
    logic [31:0]      m_addr;
    logic             m_rd, m_wr, m_wait, m_rdv;
    logic [DW-1:0]    m_wd, m_rdata;
    logic [7:0]       m_be;
    int tests = 0;
    int fails = 0;

    accel_mem_bridge_mp #(.NUM_PORTS(NP), .DATA_W(DW), .MAX_PENDING(8)) dut (
        .clk(clk), .reset(reset),
        .avs_accel_writedata(wdata), .avs_accel_read(rd), .avs_accel_write(wr),
        .avs_accel_waitrequest(waitreq), .avs_accel_readdata(rdata),
        .avs_accel_readdatavalid(rvalid),
        .avm_mem_address(m_addr), .avm_mem_read(m_rd), .avm_mem_write(m_wr),
        .avm_mem_writedata(m_wd), .avm_mem_byteenable(m_be),
        .avm_mem_waitrequest(m_wait), .avm_mem_readdata(m_rdata),
        .avm_mem_readdatavalid(m_rdv)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  wr;
        logic [1:0]  rd;
        logic [97:0] cmd0;
        logic [97:0] cmd1;
        logic [1:0]  exp_wait;
        logic        exp_wr;
        logic        exp_rd;
        logic [31:0] exp_addr;
        logic [7:0]  exp_be;
        logic [63:0] exp_wd;
    } vec_t;

    vec_t vecs[10];

    int          pl_port[9] = '{0, 1, 0, 1, 0, 1, 0, 1, 0};
    logic [31:0] pl_addr[9] = '{32'h100, 32'h104, 32'h108, 32'h10A, 32'h10F, 32'h110, 32'h115, 32'h11C, 32'h120};
    logic [1:0]  pl_size[9] = '{2'd0, 2'd2, 2'd2, 2'd1, 2'd0, 2'd3, 2'd0, 2'd1, 2'd2};
    logic [63:0] pl_exp[9]  = '{64'h88, 64'h11223344, 64'h55667788, 64'h5566, 64'h11,
                                64'h1122334455667788, 64'h33, 64'h3344, 64'h55667788};

    function automatic logic [97:0] mk(input logic [1:0] sz, input logic [63:0] d, input logic [31:0] a);
        return {sz, d, a};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rd = '0; wr = '0; wdata = '0; m_wait = 1'b0; m_rdv = 1'b0; m_rdata = '0;
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [NP-1:0] exp_v;
        vecs[0] = '{2'b10, 2'b00, mk(2'd0, 64'h0, 32'h0), mk(2'd1, 64'hBEEF, 32'h1003),
                    2'b00, 1'b1, 1'b0, 32'h1000, 8'h18, 64'h000000BEEF000000};
        vecs[1] = '{2'b11, 2'b00, mk(2'd3, 64'h0123456789ABCDEF, 32'h2000), mk(2'd2, 64'hCAFEF00D, 32'h3004),
                    2'b10, 1'b1, 1'b0, 32'h2000, 8'hFF, 64'h0123456789ABCDEF};
        vecs[2] = '{2'b11, 2'b00, mk(2'd3, 64'h0123456789ABCDEF, 32'h2000), mk(2'd2, 64'hCAFEF00D, 32'h3004),
                    2'b01, 1'b1, 1'b0, 32'h3000, 8'hF0, 64'hCAFEF00D00000000};
        vecs[3] = '{2'b01, 2'b00, mk(2'd0, 64'hA5, 32'h4001), mk(2'd0, 64'h0, 32'h0),
                    2'b00, 1'b1, 1'b0, 32'h4000, 8'h02, 64'h000000000000A500};
        vecs[4] = '{2'b00, 2'b00, mk(2'd0, 64'h0, 32'h0), mk(2'd0, 64'h0, 32'h0),
                    2'b00, 1'b0, 1'b0, 32'h0, 8'h00, 64'h0};
        vecs[5] = '{2'b10, 2'b00, mk(2'd0, 64'h0, 32'h0), mk(2'd2, 64'h11223344, 32'h5006),
                    2'b00, 1'b1, 1'b0, 32'h5000, 8'hC0, 64'h3344000000000000};
        vecs[6] = '{2'b01, 2'b01, mk(2'd3, 64'hDEADBEEF, 32'h6000), mk(2'd0, 64'h0, 32'h0),
                    2'b00, 1'b1, 1'b0, 32'h6000, 8'hFF, 64'h00000000DEADBEEF};
        vecs[7] = '{2'b00, 2'b10, mk(2'd0, 64'h0, 32'h0), mk(2'd1, 64'h0, 32'h7002),
                    2'b00, 1'b0, 1'b1, 32'h7000, 8'h0C, 64'h0};
        vecs[8] = '{2'b10, 2'b01, mk(2'd2, 64'h0, 32'h8000), mk(2'd0, 64'h77, 32'h9000),
                    2'b10, 1'b0, 1'b1, 32'h8000, 8'h0F, 64'h0};
        vecs[9] = '{2'b10, 2'b01, mk(2'd2, 64'h0, 32'h8000), mk(2'd0, 64'h77, 32'h9000),
                    2'b01, 1'b1, 1'b0, 32'h9000, 8'h01, 64'h77};

        // Reset state, with a request pending to show grant is held off
        reset = 1'b1; rd = '0; m_wait = 1'b0; m_rdv = 1'b0; m_rdata = '0;
        wr = 2'b01; wdata = '0; wdata[0 +: AW] = mk(2'd3, 64'h1, 32'h40);
        step(); step();
        chk("rst_rd", 64'(m_rd), 64'h0);
        chk("rst_wr", 64'(m_wr), 64'h0);
        chk("rst_addr", 64'(m_addr), 64'h0);
        chk("rst_be", 64'(m_be), 64'h0);
        chk("rst_wd", m_wd, 64'h0);
        chk("rst_rvalid", 64'(rvalid), 64'h0);
        chk("rst_rdata0", rdata[0 +: DW], 64'h0);
        chk("rst_rdata1", rdata[DW +: DW], 64'h0);
        chk("rst_wait", 64'(waitreq), 64'h1);
        do_reset();

        // Vector table: one issue cycle per entry, no memory stall
        for (int i = 0; i < 10; i++) begin
            wr = vecs[i].wr; rd = vecs[i].rd; wdata = {vecs[i].cmd1, vecs[i].cmd0};
            #1;
            chk($sformatf("v%0d_wait", i), 64'(waitreq), 64'(vecs[i].exp_wait));
            step();
            chk($sformatf("v%0d_wr", i), 64'(m_wr), 64'(vecs[i].exp_wr));
            chk($sformatf("v%0d_rd", i), 64'(m_rd), 64'(vecs[i].exp_rd));
            if (vecs[i].exp_wr | vecs[i].exp_rd) begin
                chk($sformatf("v%0d_addr", i), 64'(m_addr), 64'(vecs[i].exp_addr));
                chk($sformatf("v%0d_be", i), 64'(m_be), 64'(vecs[i].exp_be));
            end
            if (vecs[i].exp_wr) begin
                chk($sformatf("v%0d_wd", i), m_wd, vecs[i].exp_wd);
            end
        end

        // Single read with lane alignment and response latency
        do_reset();
        rd = 2'b01; wdata[0 +: AW] = mk(2'd1, 64'h0, 32'h2006);
        #1 chk("rdA_wait", 64'(waitreq), 64'h0);
        step();
        chk("rdA_mrd", 64'(m_rd), 64'h1);
        chk("rdA_addr", 64'(m_addr), 64'h2000);
        chk("rdA_be", 64'(m_be), 64'hC0);
        rd = '0;
        step();
        chk("rdA_mrd_off", 64'(m_rd), 64'h0);
        m_rdv = 1'b1; m_rdata = MEMD;
        #1 chk("rdA_not_early", 64'(rvalid), 64'h0);
        step();
        m_rdv = 1'b0;
        chk("rdA_valid", 64'(rvalid), 64'h1);
        chk("rdA_data0", rdata[0 +: DW], 64'h1122);
        chk("rdA_data1", rdata[DW +: DW], 64'h0);
        step();
        chk("rdA_valid_off", 64'(rvalid), 64'h0);
        chk("rdA_data_hold", rdata[0 +: DW], 64'h1122);

        // Contention: both ports write every cycle, grants alternate
        do_reset();
        wr = 2'b11;
        wdata[0 +: AW]  = mk(2'd3, 64'hA, 32'hA000);
        wdata[AW +: AW] = mk(2'd3, 64'hB, 32'hB000);
        for (int c = 0; c < 8; c++) begin
            #1 chk($sformatf("cont%0d_wait", c), 64'(waitreq), (c % 2 == 0) ? 64'h2 : 64'h1);
            step();
            chk($sformatf("cont%0d_addr", c), 64'(m_addr), (c % 2 == 0) ? 64'hA000 : 64'hB000);
        end

        // Backpressure: command held for 5 stalled cycles, no duplicate afterwards
        do_reset();
        wr = 2'b01; wdata[0 +: AW] = mk(2'd3, 64'h1111, 32'h100);
        step();
        m_wait = 1'b1; wr = 2'b11;
        wdata[0 +: AW]  = mk(2'd3, 64'h2222, 32'h200);
        wdata[AW +: AW] = mk(2'd3, 64'h3333, 32'h300);
        for (int c = 0; c < 5; c++) begin
            #1 chk($sformatf("bp%0d_wait", c), 64'(waitreq), 64'h3);
            step();
            chk($sformatf("bp%0d_wr", c), 64'(m_wr), 64'h1);
            chk($sformatf("bp%0d_addr", c), 64'(m_addr), 64'h100);
            chk($sformatf("bp%0d_wd", c), m_wd, 64'h1111);
        end
        m_wait = 1'b0;
        #1 chk("bp_rel_wait", 64'(waitreq), 64'h1);
        step();
        chk("bp_next_addr", 64'(m_addr), 64'h300);
        chk("bp_next_wd", m_wd, 64'h3333);
        wr = 2'b01;
        #1 chk("bp_p0_wait", 64'(waitreq), 64'h0);
        step();
        chk("bp_p0_addr", 64'(m_addr), 64'h200);
        wr = 2'b00;
        step();
        chk("bp_idle_wr", 64'(m_wr), 64'h0);

        // Pending limit: 8 reads fill the FIFO, the 9th waits for a pop
        do_reset();
        for (int i = 0; i < 8; i++) begin
            rd = '0; rd[pl_port[i]] = 1'b1;
            wdata = '0; wdata[pl_port[i]*AW +: AW] = mk(pl_size[i], 64'h0, pl_addr[i]);
            #1 chk($sformatf("pl%0d_wait", i), 64'(waitreq), 64'h0);
            step();
        end
        rd = 2'b01; wr = 2'b10;
        wdata[0 +: AW]  = mk(pl_size[8], 64'h0, pl_addr[8]);
        wdata[AW +: AW] = mk(2'd3, 64'h55, 32'h500);
        #1 chk("pl_full_wait", 64'(waitreq), 64'h1);
        step();
        chk("pl_full_wr", 64'(m_wr), 64'h1);
        chk("pl_full_waddr", 64'(m_addr), 64'h500);
        wr = 2'b00;
        for (int c = 0; c < 2; c++) begin
            #1 chk($sformatf("pl_stall%0d", c), 64'(waitreq), 64'h1);
            step();
        end
        m_rdv = 1'b1; m_rdata = MEMD;
        #1 chk("pl_pop_cycle_wait", 64'(waitreq), 64'h1);
        step();
        m_rdv = 1'b0;
        chk("pl_rsp0_valid", 64'(rvalid), 64'h1);
        chk("pl_rsp0_data", rdata[0 +: DW], pl_exp[0]);
        #1 chk("pl_after_pop_wait", 64'(waitreq), 64'h0);
        step();
        chk("pl_9th_rd", 64'(m_rd), 64'h1);
        chk("pl_9th_addr", 64'(m_addr), 64'h120);
        rd = '0;
        for (int k = 1; k < 9; k++) begin
            m_rdv = 1'b1;
            step();
            exp_v = '0; exp_v[pl_port[k]] = 1'b1;
            chk($sformatf("pl_rsp%0d_valid", k), 64'(rvalid), 64'(exp_v));
            chk($sformatf("pl_rsp%0d_data", k), rdata[pl_port[k]*DW +: DW], pl_exp[k]);
        end
        m_rdv = 1'b0;
        step();
        chk("pl_drained", 64'(rvalid), 64'h0);

        // Reset in the middle of traffic with 3 reads outstanding
        do_reset();
        rd = 2'b01; wdata[0 +: AW] = mk(2'd0, 64'h0, 32'h100);
        step();
        rd = '0; m_rdv = 1'b1; m_rdata = MEMD;
        step();
        m_rdv = 1'b0;
        chk("mr_pre_data", rdata[0 +: DW], 64'h88);
        for (int i = 0; i < 3; i++) begin
            rd = '0; rd[i % 2] = 1'b1;
            wdata = '0; wdata[(i % 2)*AW +: AW] = mk(2'd2, 64'h0, 32'h108 + 32'(8*i));
            step();
        end
        chk("mr_pre_rd", 64'(m_rd), 64'h1);
        rd = '0;
        reset = 1'b1;
        #1;
        chk("mr_rd", 64'(m_rd), 64'h0);
        chk("mr_addr", 64'(m_addr), 64'h0);
        chk("mr_be", 64'(m_be), 64'h0);
        chk("mr_rvalid", 64'(rvalid), 64'h0);
        chk("mr_rdata0", rdata[0 +: DW], 64'h0);
        step();
        reset = 1'b0;
        step();
        for (int i = 0; i < 3; i++) begin
            m_rdv = 1'b1;
            step();
            chk($sformatf("mr_drop%0d", i), 64'(rvalid), 64'h0);
        end
        m_rdv = 1'b0;
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
